// File: rtl/ddr4_cmd_sequencer.sv
// Closed-page DDR4 command sequencer: one request at a time, ACT -> RD/WR -> PRE with fixed
// spacing, write data/strobe drive and registered read-data capture.
module ddr4_cmd_sequencer #(
  parameter int unsigned ADDRWIDTH  = 17,
  parameter int unsigned BGWIDTH    = 2,
  parameter int unsigned BAWIDTH    = 2,
  parameter int unsigned CADDRWIDTH = 10,
  parameter int unsigned DQWIDTH    = 72,
  parameter int unsigned DQSWIDTH   = 18,
  parameter int unsigned BL         = 8,
  parameter int unsigned TRCD       = 4,
  parameter int unsigned CL         = 4,
  parameter int unsigned CWL        = 3,
  parameter int unsigned TWR        = 4,
  parameter int unsigned TRP        = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [CADDRWIDTH-1:0] req_col,
  input  logic [DQWIDTH-1:0]    req_wdata,
  output logic                  rd_valid,
  output logic [DQWIDTH-1:0]    rd_data,
  output logic                  cke,
  output logic                  cs_n,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BGWIDTH-1:0]    bg,
  output logic [BAWIDTH-1:0]    ba,
  output logic [DQWIDTH-1:0]    dq_out,
  input  logic [DQWIDTH-1:0]    dq_in,
  output logic                  dq_oe,
  output logic [DQSWIDTH-1:0]   dqs_t_out,
  output logic [DQSWIDTH-1:0]   dqs_c_out,
  output logic                  odt
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] One     = CntW'(1);
  // Gap states last (parameter - 1) cycles because the command cycle itself counts as one.
  localparam logic [CntW-1:0] TrcdGap = CntW'(TRCD - 1);
  localparam logic [CntW-1:0] ClGap   = CntW'(CL - 1);
  localparam logic [CntW-1:0] CwlGap  = CntW'(CWL - 1);
  localparam logic [CntW-1:0] BeatLd  = CntW'(BL / 2 - 1);
  localparam logic [CntW-1:0] TwrLd   = CntW'(TWR - 1);
  localparam logic [CntW-1:0] TrpLd   = CntW'(TRP - 1);

  typedef enum logic [3:0] {
    StIdle, StAct, StTrcd, StCas, StLat, StBurst, StTwr, StPre, StTrp
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      lat_gap;
  logic                 we_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [CADDRWIDTH-1:0] col_q;
  logic [DQWIDTH-1:0]   wdata_q;
  logic                 ph_q;
  logic                 accept;
  logic                 wr_beat;
  logic                 rd_beat;

  assign req_ready = cke && (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign lat_gap   = we_q ? CwlGap : ClGap;
  assign wr_beat   = (state_q == StBurst) && we_q;
  assign rd_beat   = (state_q == StBurst) && !we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cke     <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cke     <= 1'b1;
      ph_q    <= wr_beat ? ~ph_q : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      bg_q    <= '0;
      ba_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      bg_q    <= req_bg;
      ba_q    <= req_ba;
      row_q   <= req_row;
      col_q   <= req_col;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_beat;
      if (rd_beat) begin
        rd_data <= dq_in;
      end
    end
  end

  // Zero-length gap states are skipped so TRCD/CL/CWL of 1 still work.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StAct;
      StAct: begin
        if (TrcdGap == '0) begin
          state_d = StCas;
        end else begin
          state_d = StTrcd;
          cnt_d   = TrcdGap - One;
        end
      end
      StTrcd: begin
        if (cnt_q == '0) state_d = StCas;
        else             cnt_d   = cnt_q - One;
      end
      StCas: begin
        if (lat_gap == '0) begin
          state_d = StBurst;
          cnt_d   = BeatLd;
        end else begin
          state_d = StLat;
          cnt_d   = lat_gap - One;
        end
      end
      StLat: begin
        if (cnt_q == '0) begin
          state_d = StBurst;
          cnt_d   = BeatLd;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
      StBurst: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - One;
        end else if (we_q) begin
          state_d = StTwr;
          cnt_d   = TwrLd;
        end else begin
          state_d = StPre;
        end
      end
      StTwr: begin
        if (cnt_q == '0) state_d = StPre;
        else             cnt_d   = cnt_q - One;
      end
      StPre: begin
        state_d = StTrp;
        cnt_d   = TrpLd;
      end
      StTrp: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - One;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_n  = 1'b1;
    act_n = 1'b1;
    A     = '0;
    unique case (state_q)
      StAct: begin
        cs_n  = 1'b0;
        act_n = 1'b0;
        A     = row_q;
      end
      StCas: begin
        cs_n                = 1'b0;
        A[16:14]            = we_q ? 3'b100 : 3'b101;
        A[CADDRWIDTH-1:0]   = col_q;
      end
      StPre: begin
        cs_n     = 1'b0;
        A[16:14] = 3'b010;
      end
      default: ;
    endcase
  end

  assign bg        = bg_q;
  assign ba        = ba_q;
  assign dq_oe     = wr_beat;
  assign odt       = wr_beat;
  assign dq_out    = wr_beat ? wdata_q : '0;
  assign dqs_t_out = wr_beat ? {DQSWIDTH{ph_q}} : '1;
  assign dqs_c_out = ~dqs_t_out;

endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// Self-checking bench for ddr4_cmd_sequencer: per-cycle pin comparison against a timeline model
// derived from the command spacing rules.
module tb_ddr4_cmd_sequencer;

  localparam int AW = 17, BGW = 2, BAW = 2, CW = 10, DW = 72, SW = 18;
  localparam int BL = 8, TRCD = 4, CL = 4, CWL = 3, TWR = 4, TRP = 4;
  localparam int PW = 1 + 1 + AW + BGW + BAW + 1 + 1 + DW + SW + SW + 1 + 1 + DW + 1;

  typedef struct packed {
    logic          we;
    logic [BGW-1:0] bg;
    logic [BAW-1:0] ba;
    logic [AW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rbase;
  } req_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic [BGW-1:0] req_bg = '0;
  logic [BAW-1:0] req_ba = '0;
  logic [AW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic [DW-1:0] req_wdata = '0, dq_in = '0;
  logic req_ready, rd_valid, cke, cs_n, act_n, dq_oe, odt;
  logic [DW-1:0] rd_data, dq_out;
  logic [AW-1:0] A;
  logic [BGW-1:0] bg;
  logic [BAW-1:0] ba;
  logic [SW-1:0] dqs_t, dqs_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ddr4_cmd_sequencer #(
    .ADDRWIDTH(AW), .BGWIDTH(BGW), .BAWIDTH(BAW), .CADDRWIDTH(CW), .DQWIDTH(DW),
    .DQSWIDTH(SW), .BL(BL), .TRCD(TRCD), .CL(CL), .CWL(CWL), .TWR(TWR), .TRP(TRP)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .req_wdata(req_wdata), .rd_valid(rd_valid), .rd_data(rd_data), .cke(cke), .cs_n(cs_n),
    .act_n(act_n), .A(A), .bg(bg), .ba(ba), .dq_out(dq_out), .dq_in(dq_in), .dq_oe(dq_oe),
    .dqs_t_out(dqs_t), .dqs_c_out(dqs_c), .odt(odt)
  );

  // Timeline relative to the acceptance edge t0.
  function automatic int t_d0(req_t r);
    return 1 + TRCD + (r.we ? CWL : CL);
  endfunction

  function automatic int t_pre(req_t r);
    int tdl;
    tdl = t_d0(r) + BL / 2 - 1;
    return r.we ? tdl + TWR + 1 : tdl + 1;
  endfunction

  function automatic int t_rdy(req_t r);
    return t_pre(r) + TRP + 1;
  endfunction

  function automatic logic [PW-1:0] exp_pins(req_t r, int t);
    int td0, tdl, tcas, tpre;
    logic cs_e, act_e, oe, rv;
    logic [AW-1:0] a_e;
    logic [DW-1:0] dout, rdat;
    logic [SW-1:0] st;
    tcas  = 1 + TRCD;
    td0   = t_d0(r);
    tdl   = td0 + BL / 2 - 1;
    tpre  = t_pre(r);
    cs_e  = !(t == 1 || t == tcas || t == tpre);
    act_e = (t != 1);
    a_e   = '0;
    if (t == 1) a_e = r.row;
    else if (t == tcas) a_e = (r.we ? 17'h10000 : 17'h14000) | AW'(r.col);
    else if (t == tpre) a_e = 17'h08000;
    oe   = r.we && t >= td0 && t <= tdl;
    dout = oe ? r.wdata : '0;
    st   = (oe && ((t - td0) % 2 == 0)) ? '0 : '1;
    rv   = !r.we && t > td0 && t <= tdl + 1;
    rdat = rv ? r.rbase + DW'(t - 1 - td0) : '0;
    return {cs_e, act_e, a_e, r.bg, r.ba, oe, oe, dout, st, ~st, (t >= t_rdy(r)), rv, rdat, 1'b1};
  endfunction

  function automatic logic [PW-1:0] rst_pins();
    return {1'b1, 1'b1, {AW{1'b0}}, {BGW{1'b0}}, {BAW{1'b0}}, 1'b0, 1'b0, {DW{1'b0}},
            {SW{1'b1}}, {SW{1'b0}}, 1'b0, 1'b0, {DW{1'b0}}, 1'b0};
  endfunction

  function automatic logic [PW-1:0] obs_pins();
    return {cs_n, act_n, A, bg, ba, dq_oe, odt, dq_out, dqs_t, dqs_c, req_ready, rd_valid,
            rd_data & {DW{rd_valid}}, cke};
  endfunction

  function automatic req_t rand_req(logic we);
    req_t r;
    r.we    = we;
    r.bg    = BGW'($urandom);
    r.ba    = BAW'($urandom);
    r.row   = AW'($urandom);
    r.col   = CW'($urandom);
    r.wdata = DW'({$urandom, $urandom, $urandom});
    r.rbase = DW'({$urandom, $urandom, $urandom});
    return r;
  endfunction

  task automatic drive_req(req_t r);
    req_we = r.we; req_bg = r.bg; req_ba = r.ba; req_row = r.row;
    req_col = r.col; req_wdata = r.wdata; req_valid = 1'b1;
  endtask

  // DIMM side: beat values on read-burst cycles, noise elsewhere.
  task automatic drive_dq(req_t r, int t);
    if (!r.we && t >= t_d0(r) && t < t_d0(r) + BL / 2) dq_in = r.rbase + DW'(t - t_d0(r));
    else dq_in = DW'({$urandom, $urandom, $urandom});
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    dq_in = '0;
    #1 rst_ni = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs_pins() !== rst_pins()) begin
        fails++;
        $display("FAIL reset_vals got=%h exp=%h", obs_pins(), rst_pins());
      end
    end
    rst_ni = 1'b1;
    @(negedge clk);
    tests++;
    if ({cke, req_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_release got cke/ready=%b exp=11", {cke, req_ready});
    end
  endtask

  task automatic test_write();
    req_t r;
    r = '{we: 1'b1, bg: 2'd1, ba: 2'd2, row: 17'h1ABCD, col: 10'h3F,
          wdata: 72'h000123456789ABCDEF, rbase: '0};
    drive_req(r);
    @(posedge clk);
    for (int t = 1; t <= t_rdy(r); t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      drive_dq(r, t);
      tests++;
      if (obs_pins() !== exp_pins(r, t)) begin
        fails++;
        $display("FAIL write t=%0d got=%h exp=%h", t, obs_pins(), exp_pins(r, t));
      end
    end
  endtask

  task automatic test_read();
    req_t r;
    r = '{we: 1'b0, bg: 2'd1, ba: 2'd2, row: 17'h1ABCD, col: 10'h3F,
          wdata: '0, rbase: 72'hA0};
    drive_req(r);
    @(posedge clk);
    for (int t = 1; t <= t_rdy(r); t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      drive_dq(r, t);
      tests++;
      if (obs_pins() !== exp_pins(r, t)) begin
        fails++;
        $display("FAIL read t=%0d got=%h exp=%h", t, obs_pins(), exp_pins(r, t));
      end
    end
  endtask

  task automatic test_back_to_back();
    req_t rw, rr;
    rw = rand_req(1'b1);
    rr = rand_req(1'b0);
    drive_req(rw);
    @(posedge clk);
    for (int t = 1; t <= t_rdy(rw); t++) begin
      @(negedge clk);
      if (t == 1) drive_req(rr);
      drive_dq(rw, t);
      tests++;
      if (obs_pins() !== exp_pins(rw, t)) begin
        fails++;
        $display("FAIL b2b_write t=%0d got=%h exp=%h", t, obs_pins(), exp_pins(rw, t));
      end
    end
    @(posedge clk);
    for (int t = 1; t <= t_rdy(rr); t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      drive_dq(rr, t);
      tests++;
      if (obs_pins() !== exp_pins(rr, t)) begin
        fails++;
        $display("FAIL b2b_read t=%0d got=%h exp=%h", t + t_rdy(rw), obs_pins(), exp_pins(rr, t));
      end
    end
  endtask

  task automatic test_busy_ignore();
    req_t r;
    r = rand_req(1'b1);
    drive_req(r);
    @(posedge clk);
    for (int t = 1; t <= t_rdy(r) + 1; t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      if (t == 3) drive_req(rand_req(1'b0));
      if (t == 4) req_valid = 1'b0;
      drive_dq(r, t);
      tests++;
      if (obs_pins() !== exp_pins(r, t)) begin
        fails++;
        $display("FAIL busy_ignore t=%0d got=%h exp=%h", t, obs_pins(), exp_pins(r, t));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    req_t rw, rr;
    rw = rand_req(1'b1);
    rr = rand_req(1'b0);
    drive_req(rw);
    @(posedge clk);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      drive_dq(rw, t);
      tests++;
      if (obs_pins() !== exp_pins(rw, t)) begin
        fails++;
        $display("FAIL mid_pre t=%0d got=%h exp=%h", t, obs_pins(), exp_pins(rw, t));
      end
    end
    @(posedge clk);
    #1 rst_ni = 1'b0;
    #1;
    tests++;
    if (obs_pins() !== rst_pins()) begin
      fails++;
      $display("FAIL mid_async got=%h exp=%h", obs_pins(), rst_pins());
    end
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    tests++;
    if ({cs_n, dq_oe, rd_valid, req_ready, cke} !== 5'b10011) begin
      fails++;
      $display("FAIL mid_release got=%b exp=10011", {cs_n, dq_oe, rd_valid, req_ready, cke});
    end
    drive_req(rr);
    @(posedge clk);
    for (int t = 1; t <= t_rdy(rr); t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
      drive_dq(rr, t);
      tests++;
      if (obs_pins() !== exp_pins(rr, t)) begin
        fails++;
        $display("FAIL mid_read t=%0d got=%h exp=%h", t, obs_pins(), exp_pins(rr, t));
      end
    end
  endtask

  task automatic test_random();
    req_t r;
    for (int n = 0; n < 6; n++) begin
      r = rand_req(1'($urandom));
      drive_req(r);
      @(posedge clk);
      for (int t = 1; t <= t_rdy(r); t++) begin
        @(negedge clk);
        if (t == 1) req_valid = 1'b0;
        drive_dq(r, t);
        tests++;
        if (obs_pins() !== exp_pins(r, t)) begin
          fails++;
          $display("FAIL random n=%0d we=%0b t=%0d got=%h exp=%h", n, r.we, t, obs_pins(),
                   exp_pins(r, t));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
